// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerator dispatcher.
// The optional watchdog in accel_dispatch is enabled by ACCEL_DISPATCH_TIMEOUT_EN.
package accel_pkg;

    localparam int unsigned DATA_W = 8;

    // Result reported when the watchdog gives up on the accelerator.
    localparam logic [DATA_W-1:0] TIMEOUT_RESULT = 8'hFF;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StSettle,
        StWait,
        StHold
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } op_t;

endpackage

// File: rtl/accel_op_fifo.sv
// Synchronous operand queue with full/empty flags; DEPTH must be a power of two.
// A push while full is dropped even if a pop happens in the same cycle.
module accel_op_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/accel_dispatch.sv
// Queues operand pairs and runs them one at a time through an external sqrt/cbrt accelerator.
// Define ACCEL_DISPATCH_TIMEOUT_EN to add a WAIT-state watchdog that reports 8'hFF with err_o.
module accel_dispatch
    import accel_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              acc_rst_o,
    output logic [DATA_W-1:0] acc_a_o,
    output logic [DATA_W-1:0] acc_b_o,
    input  logic              acc_busy_i,
    input  logic [DATA_W-1:0] acc_y_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] y_o,
    output logic              err_o
);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be non-zero");
    end

    state_e            state_q;
    state_e            state_d;
    op_t               fifo_wdata;
    op_t               fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              take_op;
    logic              capture;
    logic              timeout_hit;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] y_q;

    assign in_ready_o = !fifo_full && !rst_i;
    assign fifo_push  = in_valid_i && in_ready_o;
    assign fifo_wdata = '{a: a_i, b: b_i};

    accel_op_fifo #(
        .WIDTH($bits(op_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_op_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (take_op),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (!fifo_empty) state_d = StStart;
            StStart:  state_d = StSettle;
            StSettle: state_d = StWait;
            StWait:   if (!acc_busy_i || timeout_hit) state_d = StHold;
            StHold:   if (out_ready_i) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // The head is taken on the edge into START so operands are already valid under the pulse.
    always_comb begin
        acc_rst_o   = 1'b0;
        out_valid_o = 1'b0;
        take_op     = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            StIdle:  take_op = !fifo_empty;
            StStart: acc_rst_o = 1'b1;
            StWait:  capture = !acc_busy_i || timeout_hit;
            StHold:  out_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q <= '0;
            b_q <= '0;
            y_q <= '0;
        end else begin
            if (take_op) begin
                a_q <= fifo_head.a;
                b_q <= fifo_head.b;
            end
            if (capture) begin
                y_q <= timeout_hit ? TIMEOUT_RESULT : acc_y_i;
            end
        end
    end

    assign acc_a_o = a_q;
    assign acc_b_o = b_q;
    assign y_o     = y_q;

`ifdef ACCEL_DISPATCH_TIMEOUT_EN
    localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WdogW-1:0] wdog_q;
    logic             err_q;

    // A real completion in the last allowed cycle still wins over the timeout.
    assign timeout_hit = (state_q == StWait) && acc_busy_i &&
                         (wdog_q == WdogW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == StStart) begin
                wdog_q <= '0;
            end else if (state_q == StWait) begin
                wdog_q <= wdog_q + WdogW'(1);
            end
            if (capture) begin
                err_q <= timeout_hit;
            end
        end
    end

    assign err_o = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

endmodule
